sync_fifo: RTL and testbench

- Synchronous single-clock FIFO that acts as the responder for the FIFO driver/monitor interface.
- Accepts writes (wr_en/wdata) and reads (rd_en/rdata), and reports status flags (full, empty, almost_full, almost_empty, count, overflow, underflow).
- Sits behind the verification interface as the DUT of the FIFO environment and is reusable as a general 8-bit buffering stage.

---
 rtl/sync_fifo_if.sv | 29 ++
 rtl/sync_fifo.sv | 84 ++++++++
 tb/tb_sync_fifo.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - FIFO write/read handshake and status bundle
interface sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  logic                       wr_en;
  logic [WIDTH-1:0]           wdata;
  logic                       rd_en;
  logic [WIDTH-1:0]           rdata;
  logic                       full;
  logic                       empty;
  logic                       almost_full;
  logic                       almost_empty;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       overflow;
  logic                       underflow;

  // Driver side: issues requests, observes data and status.
  modport master (
    output wr_en, wdata, rd_en,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  // FIFO side: services requests, reports data and status.
  modport slave (
    input  wr_en, wdata, rd_en,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered data and status flags
module sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic      clk,
  input  logic      rst,
  sync_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]    count_q, count_nxt;
  logic [WIDTH-1:0] rdata_q;
  logic             full_q, empty_q, almost_full_q, almost_empty_q;
  logic             overflow_q, underflow_q;
  logic             wr_acc, rd_acc;

  // Requests are qualified by the registered flags, so a rejected request has no side effects.
  always_comb begin
    wr_acc     = bus.wr_en & ~full_q;
    rd_acc     = bus.rd_en & ~empty_q;
    wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    count_nxt  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Storage array: not cleared by reset, and never written while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && wr_acc) begin
      mem[wr_ptr] <= bus.wdata;
    end
  end

  // Pointers, occupancy, read data and flags; flags follow next-count so they track count exactly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      rdata_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr_nxt;
      end
      if (rd_acc) begin
        rd_ptr  <= rd_ptr_nxt;
        rdata_q <= mem[rd_ptr];
      end
      count_q        <= count_nxt;
      full_q         <= (count_nxt == CW'(DEPTH));
      empty_q        <= (count_nxt == '0);
      almost_full_q  <= (count_nxt >= CW'(AF_LEVEL));
      almost_empty_q <= (count_nxt <= CW'(AE_LEVEL));
      overflow_q     <= bus.wr_en & full_q;
      underflow_q    <= bus.rd_en & empty_q;
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo
module tb_sync_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] last_rdata = '0;

  sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_flags(input bit exp_ovf, input bit exp_udf);
    int n;
    n = model_q.size();
    check("count",        32'(bus.count),    32'(n));
    check("full",         32'(bus.full),     32'(n == DEPTH));
    check("empty",        32'(bus.empty),    32'(n == 0));
    check("almost_full",  32'(bus.almost_full),  32'(n >= AF));
    check("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    check("overflow",     32'(bus.overflow),  32'(exp_ovf));
    check("underflow",    32'(bus.underflow), 32'(exp_udf));
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic step(input bit w, input logic [WIDTH-1:0] d, input bit r);
    bit ra, wa, ovf, udf;
    int n;
    n   = model_q.size();
    wa  = w && (n < DEPTH);
    ra  = r && (n > 0);
    ovf = w && (n == DEPTH);
    udf = r && (n == 0);
    bus.wr_en = w;
    bus.wdata = d;
    bus.rd_en = r;
    if (ra) exp_q.push_back(model_q.pop_front());
    if (wa) model_q.push_back(d);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    if (ra) begin
      if (exp_q.size() > 0) last_rdata = exp_q.pop_front();
      check("rdata", 32'(bus.rdata), 32'(last_rdata));
    end else begin
      check("rdata_hold", 32'(bus.rdata), 32'(last_rdata));
    end
    check_flags(ovf, udf);
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b0;
    bus.wr_en = 1'b1;
    bus.wdata = 8'h99;
    bus.rd_en = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    model_q.delete();
    exp_q.delete();
    last_rdata = '0;
    check("reset_rdata", 32'(bus.rdata), 32'h0);
    check_flags(1'b0, 1'b0);
  endtask

  task automatic drain();
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr_en = 1'b0;
    bus.wdata = '0;
    bus.rd_en = 1'b0;

    do_reset(2);
    step(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    drain();
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    drain();
    step(1'b1, 8'h33, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b1, 8'h90, 1'b1);
    step(1'b1, 8'h91, 1'b1);
    drain();

    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hE0 + i), 1'b0);
    do_reset(1);
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("post_reset_data", 32'(bus.rdata), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
